fifo_rr_arbiter: RTL and testbench

- Round-robin scheduler that drains four input virtual-channel FIFOs into one shared output FIFO in the transmit path.
- Issues rd_enable to the selected input FIFO and forwards the popped word to the output FIFO one cycle later.
- Allows up to BURST consecutive pops per requester and throttles on the output FIFO's almost_full/full flags.
- Aggregates FIFO error flags into a sticky error.

---
 rtl/fifo_rr_arbiter_if.sv | 32 +++
 rtl/fifo_rr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_if.sv
// rtl/fifo_rr_arbiter_if.sv - FIFO-side signal bundle for the round-robin VC arbiter
interface fifo_rr_arbiter_if #(
  parameter int data_width = 6
) ();
  logic                      arb_enable;
  logic [3:0]                in_empty;
  logic [3:0]                in_error;
  logic [4*data_width-1:0]   in_data;
  logic                      out_full;
  logic                      out_almost_full;
  logic                      out_error;
  logic [3:0]                in_rd_enable;
  logic                      out_wr_enable;
  logic [data_width-1:0]     out_data;
  logic [1:0]                grant_idx;
  logic [1:0]                state;
  logic                      error;

  modport master (
    input  arb_enable, in_empty, in_error, in_data,
    input  out_full, out_almost_full, out_error,
    output in_rd_enable, out_wr_enable, out_data,
    output grant_idx, state, error
  );

  modport slave (
    output arb_enable, in_empty, in_error, in_data,
    output out_full, out_almost_full, out_error,
    input  in_rd_enable, out_wr_enable, out_data,
    input  grant_idx, state, error
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin drain of four input FIFOs into one output FIFO
module fifo_rr_arbiter #(
  parameter int data_width = 6,
  parameter int BURST      = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_rr_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [2:0] burst_max = 3'(BURST);

  state_t     st;
  logic [1:0] grant;
  logic [1:0] ptr;
  logic [2:0] burst_cnt;
  logic       valid;
  logic [1:0] cap_idx;
  logic       err;

  logic       can_pop;
  logic [1:0] search_base;
  logic [1:0] rr_idx;
  logic [1:0] choice;
  logic       found;
  logic       pop;
  logic       rotate_now;

  assign can_pop = bus.arb_enable & ~bus.out_full & ~bus.out_almost_full;

  // Idle searches from the stored pointer; a rotation searches from the slot after the grant.
  assign search_base = (st == IDLE) ? ptr : grant + 2'd1;

  always_comb begin
    found  = 1'b0;
    choice = search_base;
    rr_idx = search_base;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = search_base + k[1:0];
      if (!bus.in_empty[rr_idx]) begin
        found  = 1'b1;
        choice = rr_idx;
      end
    end
  end

  assign pop = (st == SERVE) && can_pop && !bus.in_empty[grant] && (burst_cnt != burst_max);

  assign rotate_now = can_pop &&
                      (((st == SERVE) && ((burst_cnt == burst_max) || bus.in_empty[grant])) ||
                       ((st == STALL) && bus.in_empty[grant]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      grant     <= 2'd0;
      ptr       <= 2'd0;
      burst_cnt <= 3'd0;
      valid     <= 1'b0;
      cap_idx   <= 2'd0;
      err       <= 1'b0;
    end else begin
      valid <= pop;
      if (pop) begin
        cap_idx <= grant;
      end
      err <= err | (|bus.in_error) | bus.out_error;

      if (rotate_now) begin
        ptr       <= grant + 2'd1;
        burst_cnt <= 3'd0;
        if (found) begin
          grant <= choice;
          st    <= SERVE;
        end else begin
          st <= IDLE;
        end
      end else begin
        case (st)
          IDLE: begin
            if (can_pop && found) begin
              st        <= SERVE;
              grant     <= choice;
              burst_cnt <= 3'd0;
            end
          end
          SERVE: begin
            if (!can_pop) begin
              st <= STALL;
            end else if (pop) begin
              burst_cnt <= burst_cnt + 3'd1;
            end
          end
          STALL: begin
            if (can_pop) begin
              st <= SERVE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_rd_enable  = pop ? (4'b0001 << grant) : 4'b0000;
  assign bus.out_wr_enable = valid;
  // The input FIFO's output register already holds the popped word one cycle after the pop.
  assign bus.out_data      = valid ? bus.in_data[cap_idx*data_width +: data_width] : '0;
  assign bus.grant_idx     = grant;
  assign bus.state         = st;
  assign bus.error         = err;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fifo_rr_arbiter_if #(.data_width(6)) bus ();

  fifo_rr_arbiter #(.data_width(6), .BURST(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Input FIFO models: ld counts words loaded, pc counts words popped.
  logic [5:0] mem [4][64];
  int         ld [4] = '{default: 0};
  int         pc [4] = '{default: 0};
  logic [5:0] dout [4] = '{default: '0};
  logic       popempty = 1'b0;

  // Output FIFO occupancy model (never drained).
  int   owr = 0;
  int   obase = 0;
  logic ovf = 1'b0;
  logic model_en = 1'b0;
  logic af_force = 1'b0;
  logic full_force = 1'b0;

  always_comb begin
    for (int i = 0; i < 4; i++) bus.in_empty[i] = (ld[i] == pc[i]);
  end
  assign bus.in_data         = {dout[3], dout[2], dout[1], dout[0]};
  assign bus.out_almost_full = af_force | (model_en && (owr - obase) >= 3);
  assign bus.out_full        = full_force | (model_en && (owr - obase) >= 4);

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.in_rd_enable[i]) begin
        if (ld[i] == pc[i]) popempty <= 1'b1;
        dout[i] <= mem[i][pc[i] % 64];
        pc[i]   <= pc[i] + 1;
      end
    end
    if (bus.out_wr_enable) begin
      if (model_en && (owr - obase) >= 4) ovf <= 1'b1;
      owr <= owr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int i, input int n, input logic [5:0] base);
    for (int k = 0; k < n; k++) mem[i][(ld[i] + k) % 64] = base + 6'(k);
    ld[i] = ld[i] + n;
  endtask

  task automatic do_reset();
    bus.arb_enable = 1'b0;
    bus.in_error   = 4'b0;
    bus.out_error  = 1'b0;
    af_force       = 1'b0;
    full_force     = 1'b0;
    model_en       = 1'b0;
    reset          = 1'b0;
    for (int i = 0; i < 4; i++) ld[i] = pc[i];
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  logic [3:0] exp_rd [12] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0};
  logic       exp_wr [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int         wi;
  int         nw;

  initial begin
    bus.arb_enable = 1'b0;
    bus.in_error   = 4'b0;
    bus.out_error  = 1'b0;
    #1;
    chk("rst_rd", 32'(bus.in_rd_enable), 32'h0);
    chk("rst_wr", 32'(bus.out_wr_enable), 32'h0);
    chk("rst_grant", 32'(bus.grant_idx), 32'h0);
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_error", 32'(bus.error), 32'h0);
    chk("rst_data", 32'(bus.out_data), 32'h0);
    do_reset();

    // Three words in FIFO0, one rotation gap back to FIFO0.
    load(0, 3, 6'h11);
    @(negedge clk); bus.arb_enable = 1'b1; #1;
    chk("t1_c0_state", 32'(bus.state), 32'h0);
    chk("t1_c0_rd", 32'(bus.in_rd_enable), 32'h0);
    step(); chk("t1_c1_state", 32'(bus.state), 32'h1); chk("t1_c1_rd", 32'(bus.in_rd_enable), 32'h1);
            chk("t1_c1_wr", 32'(bus.out_wr_enable), 32'h0);
    step(); chk("t1_c2_rd", 32'(bus.in_rd_enable), 32'h1); chk("t1_c2_wr", 32'(bus.out_wr_enable), 32'h1);
            chk("t1_c2_data", 32'(bus.out_data), 32'h11);
    step(); chk("t1_c3_rd", 32'(bus.in_rd_enable), 32'h0); chk("t1_c3_data", 32'(bus.out_data), 32'h12);
    step(); chk("t1_c4_rd", 32'(bus.in_rd_enable), 32'h1); chk("t1_c4_wr", 32'(bus.out_wr_enable), 32'h0);
    step(); chk("t1_c5_rd", 32'(bus.in_rd_enable), 32'h0); chk("t1_c5_data", 32'(bus.out_data), 32'h13);
            chk("t1_c5_wr", 32'(bus.out_wr_enable), 32'h1);
    step(); chk("t1_c6_state", 32'(bus.state), 32'h0); chk("t1_c6_wr", 32'(bus.out_wr_enable), 32'h0);

    // All four FIFOs with two words each.
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 2, 6'h20 + 6'(2 * i));
    @(negedge clk); bus.arb_enable = 1'b1; #1;
    wi = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("t2_rd_%0d", c + 1), 32'(bus.in_rd_enable), 32'(exp_rd[c]));
      chk($sformatf("t2_wr_%0d", c + 1), 32'(bus.out_wr_enable), 32'(exp_wr[c]));
      if (exp_wr[c]) begin
        chk($sformatf("t2_data_%0d", c + 1), 32'(bus.out_data), 32'h20 + 32'(wi));
        wi++;
      end
    end
    step(); chk("t2_end_state", 32'(bus.state), 32'h0);

    // almost_full mid-burst on FIFO1.
    do_reset();
    load(1, 4, 6'h30);
    @(negedge clk); bus.arb_enable = 1'b1; #1;
    step(); chk("t3_c1_grant", 32'(bus.grant_idx), 32'h1); chk("t3_c1_rd", 32'(bus.in_rd_enable), 32'h2);
    @(negedge clk); af_force = 1'b1; #1;
    chk("t3_c2_rd", 32'(bus.in_rd_enable), 32'h0); chk("t3_c2_wr", 32'(bus.out_wr_enable), 32'h1);
    chk("t3_c2_data", 32'(bus.out_data), 32'h30);
    step(); chk("t3_c3_state", 32'(bus.state), 32'h2); chk("t3_c3_rd", 32'(bus.in_rd_enable), 32'h0);
            chk("t3_c3_grant", 32'(bus.grant_idx), 32'h1);
    @(negedge clk); af_force = 1'b0; #1;
    chk("t3_c4_state", 32'(bus.state), 32'h2); chk("t3_c4_rd", 32'(bus.in_rd_enable), 32'h0);
    step(); chk("t3_c5_state", 32'(bus.state), 32'h1); chk("t3_c5_rd", 32'(bus.in_rd_enable), 32'h2);
    step(); chk("t3_c6_rd", 32'(bus.in_rd_enable), 32'h0); chk("t3_c6_data", 32'(bus.out_data), 32'h31);

    // Depth-4 output FIFO, FIFO2 holds six words.
    do_reset();
    obase    = owr;
    model_en = 1'b1;
    load(2, 6, 6'h08);
    @(negedge clk); bus.arb_enable = 1'b1; #1;
    nw = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 6) begin
        chk("t4_c6_rd", 32'(bus.in_rd_enable), 32'h0);
        chk("t4_writes_before_stall", 32'(nw), 32'd3);
      end
      if (c == 7) chk("t4_c7_state", 32'(bus.state), 32'h2);
      if (bus.out_wr_enable) nw++;
    end
    chk("t4_total_writes", 32'(nw), 32'd4);
    chk("t4_occupancy", 32'(owr - obase), 32'd4);
    chk("t4_overflow", 32'(ovf), 32'h0);
    chk("t4_end_state", 32'(bus.state), 32'h2);

    // Sticky error from a one-cycle in_error[3] pulse.
    do_reset();
    step(); chk("t5_pre", 32'(bus.error), 32'h0);
    @(negedge clk); bus.in_error = 4'b1000; #1;
    chk("t5_same_cycle", 32'(bus.error), 32'h0);
    @(negedge clk); bus.in_error = 4'b0000; #1;
    chk("t5_set", 32'(bus.error), 32'h1);
    step(); chk("t5_hold1", 32'(bus.error), 32'h1);
    step(); chk("t5_hold2", 32'(bus.error), 32'h1);
    #2; reset = 1'b0; #1;
    chk("t5_cleared", 32'(bus.error), 32'h0);

    // Asynchronous reset while popping FIFO1.
    do_reset();
    load(1, 4, 6'h38);
    @(negedge clk); bus.arb_enable = 1'b1; #1;
    step(); chk("t6_c1_rd", 32'(bus.in_rd_enable), 32'h2);
    step(); chk("t6_c2_wr", 32'(bus.out_wr_enable), 32'h1);
    #2; reset = 1'b0; #1;
    chk("t6_rst_rd", 32'(bus.in_rd_enable), 32'h0);
    chk("t6_rst_wr", 32'(bus.out_wr_enable), 32'h0);
    chk("t6_rst_data", 32'(bus.out_data), 32'h0);
    chk("t6_rst_state", 32'(bus.state), 32'h0);
    chk("t6_rst_grant", 32'(bus.grant_idx), 32'h0);
    load(0, 1, 6'h3f);
    @(negedge clk); reset = 1'b1; #1;
    chk("t6_rel_state", 32'(bus.state), 32'h0);
    step(); chk("t6_rel_serve", 32'(bus.state), 32'h1); chk("t6_rel_grant", 32'(bus.grant_idx), 32'h0);
    bus.arb_enable = 1'b0;
    step();
    chk("never_pop_empty", 32'(popempty), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
